// File: rtl/fp_classify_if.sv
// Operand/result handshake bundle for the FCLASS pipeline.
// The master side is the operand producer and result consumer; the slave side is the unit.
interface fp_classify_if #(
   parameter int unsigned BUS_WIDTH = 64
);
   logic                 in_valid;
   logic                 in_ready;
   logic [BUS_WIDTH-1:0] in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [BUS_WIDTH-1:0] out_class;
   logic                 out_sign;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_class, out_sign
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_class, out_sign
   );
endinterface

// File: rtl/fp_classify.sv
// Two-stage FCLASS unit: S1 captures field flags, S2 holds the one-hot class mask and sign.
// Both stages use valid/ready with a combinational ready chain for full throughput.
module fp_classify #(
   parameter int unsigned BUS_WIDTH = 64
) (
   input logic          clk,
   input logic          rst_n,
   input logic          flush,
   fp_classify_if.slave bus
);
   localparam int unsigned MANT_W  = (BUS_WIDTH == 32) ? 23 : 52;
   localparam int unsigned EXP_W   = BUS_WIDTH - 1 - MANT_W;
   localparam int unsigned CLASS_W = 10;

   if (BUS_WIDTH != 32 && BUS_WIDTH != 64) begin : g_bad_width
      $error("fp_classify: BUS_WIDTH must be 32 or 64");
   end

   logic s1_valid_q, s1_valid_d;
   logic s1_sign_q, s1_sign_d;
   logic s1_e_ones_q, s1_e_ones_d;
   logic s1_e_zero_q, s1_e_zero_d;
   logic s1_m_zero_q, s1_m_zero_d;
   logic s1_m_msb_q, s1_m_msb_d;

   logic               s2_valid_q, s2_valid_d;
   logic [CLASS_W-1:0] s2_class_q, s2_class_d;
   logic               s2_sign_q, s2_sign_d;

   logic               s2_advance_c;
   logic               s1_advance_c;
   logic               in_fire_c;
   logic               s1_move_c;
   logic [EXP_W-1:0]   exp_c;
   logic [MANT_W-1:0]  mant_c;
   logic [CLASS_W-1:0] class_c;

   assign s2_advance_c = !s2_valid_q || bus.out_ready;
   assign s1_advance_c = !s1_valid_q || s2_advance_c;
   assign in_fire_c    = bus.in_valid && s1_advance_c;
   assign s1_move_c    = s1_valid_q && s2_advance_c;

   assign exp_c  = bus.in_data[BUS_WIDTH-2 -: EXP_W];
   assign mant_c = bus.in_data[MANT_W-1:0];

   // One-hot RISC-V class from the S1 flags; NaN classes ignore the sign.
   always_comb begin
      class_c = '0;
      if (s1_e_ones_q) begin
         if (s1_m_zero_q) begin
            if (s1_sign_q) class_c[0] = 1'b1;
            else           class_c[7] = 1'b1;
         end else if (s1_m_msb_q) begin
            class_c[9] = 1'b1;
         end else begin
            class_c[8] = 1'b1;
         end
      end else if (s1_e_zero_q) begin
         if (s1_m_zero_q) begin
            if (s1_sign_q) class_c[3] = 1'b1;
            else           class_c[4] = 1'b1;
         end else begin
            if (s1_sign_q) class_c[2] = 1'b1;
            else           class_c[5] = 1'b1;
         end
      end else begin
         if (s1_sign_q) class_c[1] = 1'b1;
         else           class_c[6] = 1'b1;
      end
   end

   // Next-state for both stages; flush kills valids but lets data registers load freely.
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_sign_d   = s1_sign_q;
      s1_e_ones_d = s1_e_ones_q;
      s1_e_zero_d = s1_e_zero_q;
      s1_m_zero_d = s1_m_zero_q;
      s1_m_msb_d  = s1_m_msb_q;
      s2_valid_d  = s2_valid_q;
      s2_class_d  = s2_class_q;
      s2_sign_d   = s2_sign_q;

      if (in_fire_c) begin
         s1_valid_d  = 1'b1;
         s1_sign_d   = bus.in_data[BUS_WIDTH-1];
         s1_e_ones_d = &exp_c;
         s1_e_zero_d = ~|exp_c;
         s1_m_zero_d = ~|mant_c;
         s1_m_msb_d  = mant_c[MANT_W-1];
      end else if (s1_advance_c) begin
         s1_valid_d = 1'b0;
      end

      if (s1_move_c) begin
         s2_valid_d = 1'b1;
         s2_class_d = class_c;
         s2_sign_d  = s1_sign_q;
      end else if (s2_advance_c) begin
         s2_valid_d = 1'b0;
      end

      if (flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_e_ones_q <= 1'b0;
         s1_e_zero_q <= 1'b0;
         s1_m_zero_q <= 1'b0;
         s1_m_msb_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_class_q  <= '0;
         s2_sign_q   <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_sign_q   <= s1_sign_d;
         s1_e_ones_q <= s1_e_ones_d;
         s1_e_zero_q <= s1_e_zero_d;
         s1_m_zero_q <= s1_m_zero_d;
         s1_m_msb_q  <= s1_m_msb_d;
         s2_valid_q  <= s2_valid_d;
         s2_class_q  <= s2_class_d;
         s2_sign_q   <= s2_sign_d;
      end
   end

   assign bus.in_ready  = s1_advance_c;
   assign bus.out_valid = s2_valid_q;
   assign bus.out_class = BUS_WIDTH'(s2_class_q);
   assign bus.out_sign  = s2_sign_q;
endmodule

// File: tb/tb_fp_classify.sv
// Bench for fp_classify: 64- and 32-bit instances, vector table, corner sequences,
// random valid/ready stream, all checked through per-instance scoreboards.
module tb_fp_classify;
   logic clk = 1'b0;
   logic rst_n;
   logic flush;

   always #5 clk = ~clk;

   fp_classify_if #(.BUS_WIDTH(64)) b64 ();
   fp_classify_if #(.BUS_WIDTH(32)) b32 ();

   fp_classify #(.BUS_WIDTH(64)) u_dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64));
   fp_classify #(.BUS_WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32));

   typedef struct {
      logic [9:0] cls;
      logic       sgn;
      int         cyc;
   } exp_t;

   typedef struct {
      bit          w32;
      logic [63:0] data;
      logic [9:0]  cls;
      logic        sgn;
   } vec_t;

   exp_t q64[$];
   exp_t q32[$];
   int   nchk = 0;
   int   nerr = 0;
   int   cyc  = 0;
   bit   lat_chk = 1'b0;

   logic [9:0] e64_cls, e32_cls;
   logic       e64_sgn, e32_sgn;

   vec_t tbl[11];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Independent FCLASS reference: returns {sign, class[9:0]}.
   function automatic logic [10:0] ref_fclass(input logic [63:0] d, input bit w32);
      int unsigned mw   = w32 ? 23 : 52;
      int unsigned ew   = w32 ? 8 : 11;
      logic [63:0] emax = (64'd1 << ew) - 64'd1;
      logic [63:0] e    = (d >> mw) & emax;
      logic [63:0] m    = d & ((64'd1 << mw) - 64'd1);
      logic        s    = d[mw + ew];
      logic        qbit = d[mw - 1];
      int          idx;
      logic [9:0]  r;
      if (e == emax) idx = (m == 0) ? (s ? 0 : 7) : (qbit ? 9 : 8);
      else if (e == 0) idx = (m == 0) ? (s ? 3 : 4) : (s ? 2 : 5);
      else idx = s ? 1 : 6;
      r = 10'd1 << idx;
      return {s, r};
   endfunction

   function automatic logic [63:0] rand_op(input bit w32);
      int unsigned mw    = w32 ? 23 : 52;
      int unsigned ew    = w32 ? 8 : 11;
      logic [63:0] emax  = (64'd1 << ew) - 64'd1;
      logic [63:0] mmask = (64'd1 << mw) - 64'd1;
      logic [63:0] e, m, s;
      case ($urandom % 4)
         0:       e = 64'd0;
         1:       e = emax;
         default: e = {$urandom, $urandom} & emax;
      endcase
      case ($urandom % 4)
         0:       m = 64'd0;
         1:       m = 64'd1 << (mw - 1);
         2:       m = 64'd1;
         default: m = {$urandom, $urandom} & mmask;
      endcase
      s = 64'($urandom % 2);
      return (s << (mw + ew)) | (e << mw) | m;
   endfunction

   // Scoreboards: push at input transfer, pop and compare at output transfer.
   always @(negedge clk) begin
      if (rst_n) begin
         if (b64.out_valid && b64.out_ready) begin
            if (q64.size() == 0) begin
               nchk++; nerr++;
               $display("FAIL out64_unexpected: got class %h with empty queue", b64.out_class);
            end else begin
               exp_t e;
               e = q64.pop_front();
               chk("out64_class", b64.out_class, {54'd0, e.cls});
               chk("out64_sign", {63'd0, b64.out_sign}, {63'd0, e.sgn});
               if (lat_chk) chk("out64_latency", 64'(cyc), 64'(e.cyc + 2));
            end
         end
         if (flush) q64.delete();
         else if (b64.in_valid && b64.in_ready) q64.push_back('{e64_cls, e64_sgn, cyc});
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (b32.out_valid && b32.out_ready) begin
            if (q32.size() == 0) begin
               nchk++; nerr++;
               $display("FAIL out32_unexpected: got class %h with empty queue", b32.out_class);
            end else begin
               exp_t e;
               e = q32.pop_front();
               chk("out32_class", {32'd0, b32.out_class}, {54'd0, e.cls});
               chk("out32_sign", {63'd0, b32.out_sign}, {63'd0, e.sgn});
               if (lat_chk) chk("out32_latency", 64'(cyc), 64'(e.cyc + 2));
            end
         end
         if (flush) q32.delete();
         else if (b32.in_valid && b32.in_ready) q32.push_back('{e32_cls, e32_sgn, cyc});
      end
   end

   // Present one operand and hold it until accepted; returns at posedge+1.
   task automatic send(input bit w32, input logic [63:0] d, input logic [9:0] c, input logic s);
      bit acc = 1'b0;
      if (w32) begin
         b64.in_valid = 1'b0;
         b32.in_data = d[31:0]; e32_cls = c; e32_sgn = s; b32.in_valid = 1'b1;
      end else begin
         b32.in_valid = 1'b0;
         b64.in_data = d; e64_cls = c; e64_sgn = s; b64.in_valid = 1'b1;
      end
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         acc = w32 ? b32.in_ready : b64.in_ready;
         @(posedge clk);
         #1;
         if (acc) break;
      end
      if (!acc) begin
         nchk++; nerr++;
         $display("FAIL send_timeout: operand %h never accepted", d);
      end
   endtask

   task automatic new_op(input bit w32);
      logic [63:0] d;
      logic [10:0] r;
      d = rand_op(w32);
      r = ref_fclass(d, w32);
      if (w32) begin
         b32.in_data = d[31:0]; e32_cls = r[9:0]; e32_sgn = r[10];
      end else begin
         b64.in_data = d; e64_cls = r[9:0]; e64_sgn = r[10];
      end
   endtask

   initial begin
      tbl[0]  = '{1'b0, 64'hFFF0000000000000, 10'h001, 1'b1};
      tbl[1]  = '{1'b0, 64'h8000000000000000, 10'h008, 1'b1};
      tbl[2]  = '{1'b0, 64'h0000000000000001, 10'h020, 1'b0};
      tbl[3]  = '{1'b0, 64'h3FF0000000000000, 10'h040, 1'b0};
      tbl[4]  = '{1'b0, 64'h7FF0000000000000, 10'h080, 1'b0};
      tbl[5]  = '{1'b0, 64'h7FF0000000000001, 10'h100, 1'b0};
      tbl[6]  = '{1'b0, 64'hFFF8000000000000, 10'h200, 1'b1};
      tbl[7]  = '{1'b1, 64'h000000007FC00000, 10'h200, 1'b0};
      tbl[8]  = '{1'b1, 64'h0000000080400000, 10'h004, 1'b1};
      tbl[9]  = '{1'b1, 64'h0000000000000000, 10'h010, 1'b0};
      tbl[10] = '{1'b1, 64'h00000000C0000000, 10'h002, 1'b1};

      rst_n = 1'b0; flush = 1'b0;
      b64.in_valid = 1'b0; b64.in_data = '0; b64.out_ready = 1'b0;
      b32.in_valid = 1'b0; b32.in_data = '0; b32.out_ready = 1'b0;
      e64_cls = '0; e64_sgn = 1'b0; e32_cls = '0; e32_sgn = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", {63'd0, b64.out_valid}, 64'd0);
      chk("reset_out_class", b64.out_class, 64'd0);
      chk("reset_out_sign", {63'd0, b64.out_sign}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", {63'd0, b64.in_ready}, 64'd1);
      @(posedge clk);
      #1;

      // Vector table, back-to-back with no backpressure
      b64.out_ready = 1'b1; b32.out_ready = 1'b1;
      lat_chk = 1'b1;
      for (int i = 0; i < 11; i++) send(tbl[i].w32, tbl[i].data, tbl[i].cls, tbl[i].sgn);
      b64.in_valid = 1'b0; b32.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      lat_chk = 1'b0;

      // Backpressure: two accepts fill the pipe, output holds, then drains with no gap
      b64.out_ready = 1'b0;
      send(1'b0, 64'h3FF0000000000000, 10'h040, 1'b0);
      send(1'b0, 64'h8000000000000000, 10'h008, 1'b1);
      b64.in_data = 64'h7FF0000000000000; e64_cls = 10'h080; e64_sgn = 1'b0; b64.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready_low", {63'd0, b64.in_ready}, 64'd0);
         chk("bp_out_valid", {63'd0, b64.out_valid}, 64'd1);
         chk("bp_class_hold", b64.out_class, 64'h040);
         chk("bp_sign_hold", {63'd0, b64.out_sign}, 64'd0);
      end
      @(posedge clk);
      #1;
      b64.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("bp_drain_no_gap", {63'd0, b64.out_valid}, 64'd1);
         @(posedge clk);
         #1;
         if (i == 0) begin
            b64.in_data = 64'h0000000000000001; e64_cls = 10'h020; e64_sgn = 1'b0;
         end else if (i == 1) begin
            b64.in_valid = 1'b0;
         end
      end
      repeat (3) @(posedge clk);
      #1;

      // Flush with both stages full and an operand offered
      b64.out_ready = 1'b0;
      send(1'b0, 64'hFFF0000000000000, 10'h001, 1'b1);
      send(1'b0, 64'h3FF0000000000000, 10'h040, 1'b0);
      b64.in_data = 64'h7FF0000000000001; b64.in_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0; b64.in_valid = 1'b0;
      @(negedge clk);
      chk("flush_full_out_valid", {63'd0, b64.out_valid}, 64'd0);
      b64.out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      // Flush in the same cycle an operand is accepted: that operand must vanish too
      send(1'b0, 64'h8000000000000000, 10'h008, 1'b1);
      b64.in_data = 64'h0000000000000001; b64.in_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      chk("flush_accept_in_ready", {63'd0, b64.in_ready}, 64'd1);
      @(posedge clk);
      #1;
      flush = 1'b0; b64.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("flush_accept_no_output", {63'd0, b64.out_valid}, 64'd0);
      end
      @(posedge clk);
      #1;

      // Asynchronous reset with both stages full
      b64.out_ready = 1'b0;
      send(1'b0, 64'h7FF0000000000000, 10'h080, 1'b0);
      send(1'b0, 64'hFFF8000000000000, 10'h200, 1'b1);
      b64.in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", {63'd0, b64.out_valid}, 64'd0);
      chk("async_rst_out_class", b64.out_class, 64'd0);
      chk("async_rst_out_sign", {63'd0, b64.out_sign}, 64'd0);
      q64.delete(); q32.delete();
      @(posedge clk);
      #1;
      chk("rst_held_out_valid", {63'd0, b64.out_valid}, 64'd0);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", {63'd0, b64.in_ready}, 64'd1);
      chk("post_rst_out_valid", {63'd0, b64.out_valid}, 64'd0);
      @(posedge clk);
      #1;

      // Random valid/ready stream on both widths against the reference model
      begin
         int n64 = 0, n32 = 0, guard = 0;
         bit f64, f32;
         b64.in_valid = 1'b0; b32.in_valid = 1'b0;
         while ((n64 < 8000 || n32 < 2000) && guard < 60000) begin
            @(negedge clk);
            f64 = b64.in_valid && b64.in_ready;
            f32 = b32.in_valid && b32.in_ready;
            @(posedge clk);
            #1;
            guard++;
            if (f64) n64++;
            if (f32) n32++;
            if (!b64.in_valid || f64) begin
               if (n64 < 8000 && ($urandom % 4) != 0) begin
                  new_op(1'b0); b64.in_valid = 1'b1;
               end else b64.in_valid = 1'b0;
            end
            if (!b32.in_valid || f32) begin
               if (n32 < 2000 && ($urandom % 4) != 0) begin
                  new_op(1'b1); b32.in_valid = 1'b1;
               end else b32.in_valid = 1'b0;
            end
            b64.out_ready = ($urandom % 4) != 0;
            b32.out_ready = ($urandom % 4) != 0;
         end
         chk("rand_accepted64", 64'(n64), 64'd8000);
         chk("rand_accepted32", 64'(n32), 64'd2000);
      end
      b64.in_valid = 1'b0; b32.in_valid = 1'b0;
      b64.out_ready = 1'b1; b32.out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("drain_q64_empty", 64'(q64.size()), 64'd0);
      chk("drain_q32_empty", 64'(q32.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/fp_classify.md
Name: fp_classify

Overview:
- Two-stage pipelined FCLASS unit for the FPU.
- Decomposes an FP operand into sign, exponent and mantissa, then decodes its RISC-V class.
- Produces the standard 10-bit one-hot class mask, zero-extended to BUS_WIDTH, plus the extracted sign bit.
- Uses a valid/ready handshake on both sides so it can sit between operand read and integer writeback under backpressure.

Parameters:
- BUS_WIDTH, 64. Operand width. 64 means double (11-bit exponent, 52-bit mantissa). 32 means single (8-bit exponent, 23-bit mantissa). Any other value is illegal.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of all in-flight entries.
- in_valid  input  1  operand valid.
- in_ready  output  1  unit can accept the operand this cycle.
- in_data  input  BUS_WIDTH  FP operand bits.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_class  output  BUS_WIDTH  class mask in bits [9:0]; upper bits are 0.
- out_sign  output  1  sign bit of the classified operand.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0, all valid flags clear and out_valid=0, out_class=0, out_sign=0. Reset in mid-operation discards every in-flight entry.
- Field split: S=in_data[BUS_WIDTH-1], E=in_data[BUS_WIDTH-2:MANT], M=in_data[MANT-1:0].
- Stage 1 (S1) registers these decoded flags: S, E_all_ones, E_zero, M_zero, M_msb.
- Stage 2 (S2) registers the mask and the sign. out_class and out_sign come straight from S2 registers; there is no combinational path from in_data.
- Class mask, exactly one bit set:
  - bit0 = -inf (E all ones, M=0, S=1).
  - bit1 = -normal.
  - bit2 = -subnormal (E=0, M!=0, S=1).
  - bit3 = -0.
  - bit4 = +0.
  - bit5 = +subnormal.
  - bit6 = +normal.
  - bit7 = +inf.
  - bit8 = signalling NaN (E all ones, M!=0, M_msb=0).
  - bit9 = quiet NaN (E all ones, M_msb=1).
  - The NaN bits ignore sign. out_sign still reports the raw sign.
- Handshake:
  - A transfer occurs on valid&&ready at the rising edge.
  - s2_advance = !s2_valid || out_ready.
  - s1_advance = !s1_valid || s2_advance.
  - in_ready = s1_advance. It may depend combinationally on out_ready.
  - S1 loads when in_valid&&in_ready.
  - S2 loads from S1 when s1_valid&&s2_advance.
  - A stage that is vacated without a new load clears its valid flag.
- Latency: 2 cycles from input acceptance to out_valid, when there is no backpressure. Throughput is 1 per cycle.
- Stall: while out_valid=1 and out_ready=0, out_class and out_sign hold stable. S1 holds if it is full. in_ready=0 only when both stages are full.
- Simultaneous events:
  - When full with out_ready=1 and in_valid=1, S2 drains, S1 moves to S2, and the new operand enters S1 in the same edge. No bubble and no loss.
- Flush: clears s1_valid and s2_valid at the next edge. It has priority over any load in that cycle, including an input accepted in the same cycle. Data registers need not clear.
- Ordering: results leave in acceptance order. There is no reordering or dropping except on flush or reset.

Test Plan:
- Reset/idle: rst_n=0 asserted mid-stream with both stages full -> out_valid=0 and out_class=0 immediately (asynchronously). After release, in_ready=1.
- Classes, BUS_WIDTH=64, out_ready=1, back-to-back stream:
  - 0xFFF0000000000000 -> 0x001.
  - 0x8000000000000000 -> 0x008.
  - 0x0000000000000001 -> 0x020.
  - 0x3FF0000000000000 -> 0x040.
  - 0x7FF0000000000000 -> 0x080.
  - 0x7FF0000000000001 -> 0x100.
  - 0xFFF8000000000000 -> 0x200 with out_sign=1.
  - Each result appears exactly 2 cycles after acceptance, in order.
- Classes, BUS_WIDTH=32:
  - 0x7FC00000 -> 0x200.
  - 0x80400000 -> 0x004.
  - 0x00000000 -> 0x010.
  - 0xC0000000 -> 0x002.
- Backpressure: feed 4 operands with out_ready held 0 -> in_ready drops after 2 accepts and out_class holds its first value. Then set out_ready=1 for 4 cycles -> all 4 results emerge in order with no gap or duplicate.
- Flush: with both stages full, assert flush for 1 cycle together with in_valid=1 -> next cycle out_valid=0, and the flushed operand never appears.
- Random: a random valid/ready stream of 10k operands is checked against a reference FCLASS model -> zero mismatches, no lost or duplicated results.
